// File: rtl/decode_mul_arbiter.sv
// Round-robin front end that shares one pipelined signed x unsigned multiplier
// among N_REQ requesters and returns each product tagged with its requester ID.
module decode_mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int A_W     = 40,
  parameter int B_W     = 21,
  parameter int P_W     = 60,
  parameter int MUL_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*A_W-1:0]   req_a,
  input  logic [N_REQ*B_W-1:0]   req_b,
  output logic                   mul_ce,
  output logic [A_W-1:0]         mul_din0,
  output logic [B_W-1:0]         mul_din1,
  input  logic [P_W-1:0]         mul_dout,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ID_W-1:0]        res_id,
  output logic [P_W-1:0]         res_data,
  output logic                   busy
);

  logic [MUL_LAT-1:0]           vld_q;
  logic [MUL_LAT-1:0]           vld_d;
  logic [MUL_LAT-1:0][ID_W-1:0] tag_q;
  logic [MUL_LAT-1:0][ID_W-1:0] tag_d;
  logic [ID_W-1:0]              rr_ptr_q;
  logic [ID_W-1:0]              rr_ptr_d;
  logic                         any_s;
  logic [ID_W-1:0]              gnt_s;

  // Holding reset asserts ce so the external multiplier pipe flushes alongside the tracker.
  assign mul_ce    = reset | ~vld_q[MUL_LAT-1] | res_ready;
  assign res_valid = vld_q[MUL_LAT-1];
  assign res_id    = tag_q[MUL_LAT-1];
  assign res_data  = mul_dout;
  assign busy      = |vld_q;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    any_s = 1'b0;
    gnt_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any_s && req_valid[(int'(rr_ptr_q) + k) % N_REQ]) begin
        any_s = 1'b1;
        gnt_s = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
      end else begin
        any_s = any_s;
      end
    end
  end

  // Operand mux and one-hot grant; operands read as zero when nobody is asking.
  always_comb begin
    mul_din0  = '0;
    mul_din1  = '0;
    req_ready = '0;
    if (any_s) begin
      mul_din0         = req_a[gnt_s*A_W +: A_W];
      mul_din1         = req_b[gnt_s*B_W +: B_W];
      req_ready[gnt_s] = mul_ce & ~reset;
    end else begin
      req_ready = '0;
    end
  end

  // Tracker next state: shifts in lockstep with the multiplier, frozen when ce is low.
  always_comb begin
    vld_d    = vld_q;
    tag_d    = tag_q;
    rr_ptr_d = rr_ptr_q;
    if (mul_ce) begin
      for (int i = MUL_LAT - 1; i > 0; i--) begin
        vld_d[i] = vld_q[i-1];
        tag_d[i] = tag_q[i-1];
      end
      vld_d[0] = any_s;
      tag_d[0] = gnt_s;
      if (any_s) begin
        rr_ptr_d = (gnt_s == ID_W'(N_REQ - 1)) ? '0 : gnt_s + 1'b1;
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
    end else begin
      vld_d    = vld_q;
      tag_d    = tag_q;
      rr_ptr_d = rr_ptr_q;
    end
  end

  // State registers; reset discards every in-flight item.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q    <= '0;
      tag_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      vld_q    <= vld_d;
      tag_q    <= tag_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_decode_mul_arbiter.sv
// Randomized scoreboard bench for decode_mul_arbiter with a behavioural multiplier
// and a timestamp-based reference model of grants, stalls and result order.
module tb_decode_mul_arbiter;
  localparam int N    = 4;
  localparam int ID_W = 2;
  localparam int A_W  = 40;
  localparam int B_W  = 21;
  localparam int P_W  = 60;
  localparam int LAT  = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [N-1:0]       req_valid = '0;
  logic [N-1:0]       req_ready;
  logic [N*A_W-1:0]   req_a = '0;
  logic [N*B_W-1:0]   req_b = '0;
  logic               mul_ce;
  logic [A_W-1:0]     mul_din0;
  logic [B_W-1:0]     mul_din1;
  logic [P_W-1:0]     mul_dout;
  logic               res_valid;
  logic               res_ready = 1'b1;
  logic [ID_W-1:0]    res_id;
  logic [P_W-1:0]     res_data;
  logic               busy;

  decode_mul_arbiter #(.N_REQ(N), .ID_W(ID_W), .A_W(A_W), .B_W(B_W), .P_W(P_W), .MUL_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1),
    .mul_dout(mul_dout), .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: LAT stages, clock-enable gated.
  logic signed [P_W-1:0] ax, bx, mprod;
  logic [P_W-1:0] mpipe [LAT];
  assign ax       = {{(P_W-A_W){mul_din0[A_W-1]}}, mul_din0};
  assign bx       = {{(P_W-B_W){1'b0}}, mul_din1};
  assign mprod    = ax * bx;
  assign mul_dout = mpipe[LAT-1];
  always @(posedge clk) begin
    if (mul_ce) begin
      mpipe[0] <= mprod;
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end

  typedef struct {
    int             id;
    logic [P_W-1:0] data;
    longint         t;
  } item_t;

  item_t          q[$];
  longint         ce_cnt = 0;
  int             rr = 0;
  bit             mon_front_valid = 1'b0;
  bit             pend [N];
  logic [A_W-1:0] ta [N];
  logic [B_W-1:0] tb_ops [N];
  int             errors = 0;
  int             checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference product: sign-extended a times zero-extended b, truncated to P_W.
  function automatic logic [P_W-1:0] ref_prod(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    longint sa, ub, p;
    sa = longint'($signed(a));
    ub = longint'(b);
    p  = sa * ub;
    return p[P_W-1:0];
  endfunction

  task automatic new_op(input int i);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    pend[i]   = 1'b1;
    ta[i]     = r[A_W-1:0];
    tb_ops[i] = B_W'($urandom());
    case ($urandom_range(7))
      0: ta[i] = {1'b1, {(A_W-1){1'b0}}};
      1: ta[i] = {1'b0, {(A_W-1){1'b1}}};
      2: tb_ops[i] = {B_W{1'b1}};
      default: ta[i] = ta[i];
    endcase
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = pend[i];
      req_a[i*A_W +: A_W]    = ta[i];
      req_b[i*B_W +: B_W]    = tb_ops[i];
    end
  endtask

  // Model step for the current cycle: expected grant/ce, then commit the clock edge.
  task automatic evaluate();
    int           g;
    bit           exp_ce;
    logic [N-1:0] exp_rdy;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && pend[(rr + k) % N]) g = (rr + k) % N;
    end
    exp_ce  = reset || !mon_front_valid || res_ready;
    exp_rdy = '0;
    if (!reset && g >= 0 && exp_ce) exp_rdy[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("mul_ce", 64'(mul_ce), 64'(exp_ce));
    if (g < 0) begin
      check("idle_din0", 64'(mul_din0), 64'h0);
      check("idle_din1", 64'(mul_din1), 64'h0);
    end
    if (reset) begin
      q.delete();
      rr     = 0;
      ce_cnt = 0;
    end else begin
      if (exp_rdy != '0) begin
        q.push_back('{id: g, data: ref_prod(ta[g], tb_ops[g]), t: ce_cnt});
        pend[g] = 1'b0;
        rr      = (g + 1) % N;
      end
      if (exp_ce) ce_cnt++;
    end
  endtask

  task automatic run(input int n, input logic [N-1:0] allow, input int pct_req, input int pct_rdy);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < N; i++)
        if (!pend[i] && allow[i] && int'($urandom_range(99)) < pct_req) new_op(i);
      res_ready = (int'($urandom_range(99)) < pct_rdy);
      drive();
      @(negedge clk); #1;
      evaluate();
    end
  endtask

  task automatic do_reset(input int n, input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      if (mask[i]) new_op(i);
    end
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      reset     = 1'b1;
      res_ready = $urandom_range(1) == 1;
      drive();
      @(negedge clk); #1;
      evaluate();
    end
  endtask

  task automatic load(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    pend[i]   = 1'b1;
    ta[i]     = a;
    tb_ops[i] = b;
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard front.
  initial begin
    bit fv;
    forever begin
      @(negedge clk);
      fv = (q.size() > 0) && (ce_cnt - q[0].t == longint'(LAT));
      mon_front_valid = fv;
      check("res_valid", 64'(res_valid), 64'(fv));
      check("busy", 64'(busy), 64'(q.size() > 0));
      if (fv && res_valid) begin
        check("res_id", 64'(res_id), 64'(q[0].id));
        check("res_data", 64'(res_data), 64'(q[0].data));
        if (res_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; ta[i] = '0; tb_ops[i] = '0;
    end
    do_reset(3, '0);
    load(2, -40'sd3, 21'd5);
    run(LAT + 3, '0, 0, 100);
    run(20, 4'hF, 100, 100);
    run(5, 4'hF, 100, 0);
    run(6, 4'hF, 100, 100);
    do_reset(2, '0);
    run(12, 4'b1010, 100, 100);
    do_reset(2, '0);
    load(0, {1'b1, {(A_W-1){1'b0}}}, {B_W{1'b1}});
    run(LAT + 3, '0, 0, 100);
    run(400, 4'hF, 40, 70);
    run(8, 4'hF, 100, 0);
    do_reset(2, 4'b1010);
    run(4, '0, 0, 100);
    run(300, 4'hF, 60, 50);
    run(LAT + 6, '0, 0, 100);
    check("drained", 64'(q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
